// File: rtl/alu_dispatch.sv
// Two-stage decode/issue front end for the 32-bit ALU: stage A holds decoded operands, stage B the captured result.
// Optional BRANCH decode is built when ALU_DISPATCH_BRANCH_EN is defined.
module alu_dispatch #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  alu_in1,
  output logic [XLEN-1:0]  alu_in2,
  output logic [5:0]       alu_op,
  input  logic [XLEN-1:0]  alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic [4:0]       res_rd,
  output logic             res_branch,
  output logic             res_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [5:0] OP_ILL  = 6'd0,  OP_ADD  = 6'd1,  OP_SUB  = 6'd2,  OP_AND = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4,  OP_XOR  = 6'd5,  OP_SLL  = 6'd6,  OP_SRL = 6'd7;
  localparam logic [5:0] OP_SRA  = 6'd8,  OP_SLT  = 6'd9,  OP_SLTU = 6'd10, OP_EQ  = 6'd11;
  localparam logic [5:0] OP_NE   = 6'd12, OP_SGE  = 6'd13, OP_SGEU = 6'd14, OP_PASS = 6'd15;

  typedef struct packed {
    logic [4:0] rd;
    logic       br;
    logic       ill;
  } side_t;

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, shamt;
  logic [5:0]      base_op;
  logic            unused_rs_fld;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  // Shift immediates present only the shift amount, not the funct7 bits of the immediate.
  assign shamt = {{(XLEN-5){1'b0}}, instr[24:20]};
  assign unused_rs_fld = ^instr[19:15];

  always_comb begin
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  end

  logic [XLEN-1:0] in1_d, in2_d;
  logic [5:0]      op_d;
  side_t           side_d;

  always_comb begin
    op_d   = OP_ILL;
    in1_d  = '0;
    in2_d  = '0;
    side_d = '0;
    case (opc)
      OPC_OP: begin
        in1_d     = rs1_data;
        in2_d     = rs2_data;
        side_d.rd = instr[11:7];
        if (f7 == 7'b0)                          op_d = base_op;
        else if (f7 == F7_ALT && f3 == 3'b000)   op_d = OP_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101)   op_d = OP_SRA;
      end
      OPC_IMM: begin
        in1_d     = rs1_data;
        in2_d     = imm_i;
        side_d.rd = instr[11:7];
        case (f3)
          3'b001: begin
            in2_d = shamt;
            if (f7 == 7'b0) op_d = OP_SLL;
          end
          3'b101: begin
            in2_d = shamt;
            if (f7 == 7'b0)        op_d = OP_SRL;
            else if (f7 == F7_ALT) op_d = OP_SRA;
          end
          default: op_d = base_op;
        endcase
      end
      OPC_LUI: begin
        in2_d     = {instr[31:12], 12'b0};
        op_d      = OP_PASS;
        side_d.rd = instr[11:7];
      end
`ifdef ALU_DISPATCH_BRANCH_EN
      OPC_BR: begin
        in1_d     = rs1_data;
        in2_d     = rs2_data;
        side_d.br = 1'b1;
        case (f3)
          3'b000:  op_d = OP_EQ;
          3'b001:  op_d = OP_NE;
          3'b100:  op_d = OP_SLT;
          3'b101:  op_d = OP_SGE;
          3'b110:  op_d = OP_SLTU;
          3'b111:  op_d = OP_SGEU;
          default: op_d = OP_ILL;
        endcase
      end
`endif
      default: op_d = OP_ILL;
    endcase
    // Anything that failed to decode goes down as a zeroed illegal bubble.
    if (op_d == OP_ILL) begin
      in1_d      = '0;
      in2_d      = '0;
      side_d     = '0;
      side_d.ill = 1'b1;
    end
  end

  logic            a_valid_q, res_valid_q, b_adv;
  logic [XLEN-1:0] alu_in1_q, alu_in2_q, res_data_q;
  logic [5:0]      alu_op_q;
  side_t           a_side_q, res_side_q;
  logic [CNT_W-1:0] cnt_q;

  assign b_adv    = !res_valid_q || res_ready;
  assign in_ready = !a_valid_q || b_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      alu_op_q  <= '0;
      a_side_q  <= '0;
    end else if (in_ready) begin
      a_valid_q <= in_valid;
      if (in_valid) begin
        alu_in1_q <= in1_d;
        alu_in2_q <= in2_d;
        alu_op_q  <= op_d;
        a_side_q  <= side_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_side_q  <= '0;
    end else if (b_adv) begin
      res_valid_q <= a_valid_q;
      if (a_valid_q) begin
        res_data_q <= alu_out;
        res_side_q <= a_side_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (res_valid_q && res_ready && res_side_q.ill && cnt_q != {CNT_W{1'b1}})
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;
  assign alu_op      = alu_op_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_rd      = res_side_q.rd;
  assign res_branch  = res_side_q.br;
  assign res_illegal = res_side_q.ill;
  assign illegal_cnt = cnt_q;
endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: vector table through a result scoreboard, plus backpressure, counter and reset sequences.
module tb_alu_dispatch;
  logic        clk, rst_n, in_valid, res_ready;
  logic [31:0] instr, rs1_data, rs2_data;
  logic        in_ready, res_valid, res_branch, res_illegal;
  logic [31:0] alu_in1, alu_in2, alu_out, res_data;
  logic [5:0]  alu_op;
  logic [4:0]  res_rd;
  logic [15:0] illegal_cnt;

  logic        d2_in_ready, d2_res_valid, d2_res_branch, d2_res_illegal;
  logic [31:0] d2_in1, d2_in2, d2_out, d2_res_data;
  logic [5:0]  d2_op;
  logic [4:0]  d2_res_rd;
  logic [1:0]  d2_cnt;

  alu_dispatch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_op(alu_op), .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .res_branch(res_branch), .res_illegal(res_illegal),
    .illegal_cnt(illegal_cnt));

  alu_dispatch #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .alu_in1(d2_in1), .alu_in2(d2_in2),
    .alu_op(d2_op), .alu_out(d2_out), .res_valid(d2_res_valid), .res_ready(res_ready),
    .res_data(d2_res_data), .res_rd(d2_res_rd), .res_branch(d2_res_branch),
    .res_illegal(d2_res_illegal), .illegal_cnt(d2_cnt));

  function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'd1:  return a + b;
      6'd2:  return a - b;
      6'd3:  return a & b;
      6'd4:  return a | b;
      6'd5:  return a ^ b;
      6'd6:  return a << b[4:0];
      6'd7:  return a >> b[4:0];
      6'd8:  return $unsigned($signed(a) >>> b[4:0]);
      6'd9:  return {31'b0, $signed(a) < $signed(b)};
      6'd10: return {31'b0, a < b};
      6'd11: return {31'b0, a == b};
      6'd12: return {31'b0, a != b};
      6'd13: return {31'b0, $signed(a) >= $signed(b)};
      6'd14: return {31'b0, a >= b};
      6'd15: return b;
      default: return 32'b0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_op, alu_in1, alu_in2);
  assign d2_out  = alu_f(d2_op, d2_in1, d2_in2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, rs1, rs2, in1, in2, data;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic        br, ill;
  } vec_t;

  vec_t vt[$];
  vec_t sb[$];
  vec_t cur;
  int   pass_cnt = 0, total_cnt = 0, ret_cnt = 0;
  logic acc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] ins, r1, r2, input logic [5:0] op,
                              input logic [31:0] i1, i2, d, input logic [4:0] rd,
                              input logic br, ill);
    vec_t v;
    v.instr = ins; v.rs1 = r1; v.rs2 = r2; v.op = op; v.in1 = i1; v.in2 = i2;
    v.data = d; v.rd = rd; v.br = br; v.ill = ill;
    return v;
  endfunction

  function automatic vec_t mk_ill(input logic [31:0] ins, r1, r2);
    return mk(ins, r1, r2, 6'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
  endfunction

  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] it(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] bt(input logic [2:0] f3);
    return {7'b0, 5'd2, 5'd1, f3, 5'd7, 7'b1100011};
  endfunction

  // One clock: observe handshakes at the falling edge, then return just after the rising edge.
  task automatic tick();
    vec_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (res_valid && res_ready) begin
      chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_rd", {27'b0, res_rd}, {27'b0, e.rd});
        chk("res_branch", {31'b0, res_branch}, {31'b0, e.br});
        chk("res_illegal", {31'b0, res_illegal}, {31'b0, e.ill});
        ret_cnt++;
      end
    end
    if (acc) sb.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    instr = v.instr; rs1_data = v.rs1; rs2_data = v.rs2; in_valid = 1'b1; cur = v;
  endtask

  task automatic send(input vec_t v);
    drive(v);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc) break;
    end
    chk("send_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    drive(v);
    tick();
    chk("accept", {31'b0, acc}, 32'd1);
    in_valid = 1'b0;
    chk("alu_op", {26'b0, alu_op}, {26'b0, v.op});
    chk("alu_in1", alu_in1, v.in1);
    chk("alu_in2", alu_in2, v.in2);
    tick();
    chk("latency_res_valid", {31'b0, res_valid}, 32'd1);
    tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sb.delete();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t bp[4];
    vec_t v_mul;
    int   r0;
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    instr = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    cur = mk_ill(32'h0, 32'h0, 32'h0);

    vt.push_back(mk(rt(7'h00, 3'b000, 5'd3), 32'd5, 32'd7, 6'd1, 32'd5, 32'd7, 32'd12, 5'd3, 1'b0, 1'b0));
    vt.push_back(mk(rt(7'h20, 3'b000, 5'd6), 32'd5, 32'd7, 6'd2, 32'd5, 32'd7, 32'hFFFFFFFE, 5'd6, 1'b0, 1'b0));
    vt.push_back(mk(it(12'h404, 3'b101, 5'd4), 32'h80000000, 32'h0, 6'd8, 32'h80000000, 32'd4, 32'hF8000000, 5'd4, 1'b0, 1'b0));
    vt.push_back(mk_ill(it(12'h024, 3'b001, 5'd4), 32'd1, 32'd0));
    vt.push_back(mk(it(12'hFFF, 3'b100, 5'd7), 32'h0F0F0F0F, 32'h0, 6'd5, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'hF0F0F0F0, 5'd7, 1'b0, 1'b0));
    vt.push_back(mk(it(12'hFFF, 3'b011, 5'd8), 32'd5, 32'h0, 6'd10, 32'd5, 32'hFFFFFFFF, 32'd1, 5'd8, 1'b0, 1'b0));
    vt.push_back(mk({20'h12345, 5'd5, 7'b0110111}, 32'h1, 32'h2, 6'd15, 32'h0, 32'h12345000, 32'h12345000, 5'd5, 1'b0, 1'b0));
    vt.push_back(mk(rt(7'h00, 3'b010, 5'd9), 32'hFFFFFFFF, 32'd1, 6'd9, 32'hFFFFFFFF, 32'd1, 32'd1, 5'd9, 1'b0, 1'b0));
    vt.push_back(mk(rt(7'h00, 3'b111, 5'd10), 32'hFF00FF00, 32'h0FF00FF0, 6'd3, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 5'd10, 1'b0, 1'b0));
    vt.push_back(mk(rt(7'h00, 3'b101, 5'd11), 32'h80000000, 32'd31, 6'd7, 32'h80000000, 32'd31, 32'd1, 5'd11, 1'b0, 1'b0));
    vt.push_back(mk(rt(7'h20, 3'b101, 5'd13), 32'hF0000000, 32'd4, 6'd8, 32'hF0000000, 32'd4, 32'hFF000000, 5'd13, 1'b0, 1'b0));
    vt.push_back(mk_ill(rt(7'h01, 3'b000, 5'd12), 32'd3, 32'd4));
    vt.push_back(mk_ill(32'h0000007F, 32'd9, 32'd9));
    vt.push_back(mk_ill(bt(3'b010), 32'd1, 32'd1));
`ifdef ALU_DISPATCH_BRANCH_EN
    vt.push_back(mk(bt(3'b100), 32'hFFFFFFFF, 32'd1, 6'd9, 32'hFFFFFFFF, 32'd1, 32'd1, 5'd0, 1'b1, 1'b0));
    vt.push_back(mk(bt(3'b110), 32'hFFFFFFFF, 32'd1, 6'd10, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd0, 1'b1, 1'b0));
`else
    vt.push_back(mk_ill(bt(3'b100), 32'hFFFFFFFF, 32'd1));
    vt.push_back(mk_ill(bt(3'b110), 32'hFFFFFFFF, 32'd1));
`endif
    for (int k = 0; k < 4; k++)
      bp[k] = mk(it(12'(k + 1), 3'b000, 5'(k + 1)), 32'h0, 32'h0, 6'd1, 32'h0, 32'(k + 1), 32'(k + 1), 5'(k + 1), 1'b0, 1'b0);
    v_mul = mk_ill(rt(7'h01, 3'b000, 5'd12), 32'd6, 32'd7);

    // Reset state
    tick();
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_alu_op", {26'b0, alu_op}, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_cnt", {16'b0, illegal_cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    foreach (vt[i]) run_vec(vt[i]);

    // Backpressure: both stages fill, then stall for three cycles
    res_ready = 1'b0;
    r0 = ret_cnt;
    drive(bp[0]); tick(); chk("bp_acc1", {31'b0, acc}, 32'd1);
    drive(bp[1]); tick(); chk("bp_acc2", {31'b0, acc}, 32'd1);
    drive(bp[2]);
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_no_accept", {31'b0, acc}, 32'd0);
      chk("bp_res_valid", {31'b0, res_valid}, 32'd1);
      chk("bp_res_hold", res_data, 32'd1);
      chk("bp_alu_hold", alu_in2, 32'd2);
    end
    res_ready = 1'b1;
    send(bp[2]);
    send(bp[3]);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_retired", ret_cnt - r0, 32'd4);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Illegal counter and saturation of the 2-bit copy
    pulse_reset();
    chk("cnt_after_reset", {16'b0, illegal_cnt}, 32'd0);
    repeat (3) run_vec(v_mul);
    chk("cnt_three", {16'b0, illegal_cnt}, 32'd3);
    repeat (2) run_vec(v_mul);
    chk("cnt_five", {16'b0, illegal_cnt}, 32'd5);
    chk("cnt_w2_saturate", {30'b0, d2_cnt}, 32'd3);

    // Reset with both stages holding instructions
    res_ready = 1'b0;
    drive(vt[0]); tick();
    drive(vt[1]); tick();
    in_valid = 1'b0;
    chk("mid_pre_valid", {31'b0, res_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_res_valid", {31'b0, res_valid}, 32'd0);
    chk("mid_res_data", res_data, 32'd0);
    chk("mid_alu_in1", alu_in1, 32'd0);
    chk("mid_alu_in2", alu_in2, 32'd0);
    chk("mid_alu_op", {26'b0, alu_op}, 32'd0);
    chk("mid_res_rd", {27'b0, res_rd}, 32'd0);
    chk("mid_flags", {30'b0, res_branch, res_illegal}, 32'd0);
    chk("mid_cnt", {16'b0, illegal_cnt}, 32'd0);
    sb.delete();
    rst_n = 1'b1;
    res_ready = 1'b1;
    chk("mid_in_ready", {31'b0, in_ready}, 32'd1);
    run_vec(vt[6]);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Decode-and-issue stage that sits in front of the 32-bit ALU. It accepts RV32I integer ALU, LUI and conditional-branch instructions with their source-register values over a valid/ready handshake, and decodes each into the ALU's 6-bit op code and operand pair. It then captures the ALU result in an output register and presents it downstream with its destination register, branch and illegal flags. It is a two-stage pipeline with full throughput and backpressure.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `CNT_W`, 16, width of the illegal-instruction counter.

Ports:
- `clk`  in  1  single clock; all registers update on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  instruction and operands are valid.
- `in_ready`  out  1  block accepts the instruction this cycle.
- `instr`  in  32  RV32I instruction word.
- `rs1_data`  in  32  source-1 value.
- `rs2_data`  in  32  source-2 value.
- `alu_in1`  out  32  to the ALU `in1` input; registered (stage A).
- `alu_in2`  out  32  to the ALU `in2` input; registered (stage A).
- `alu_op`  out  6  to the ALU `op` input; registered (stage A).
- `alu_out`  in  32  ALU combinational result.
- `res_valid`  out  1  result register holds valid data (stage B).
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  32  captured ALU result.
- `res_rd`  out  5  destination register; 0 for branches and illegal instructions.
- `res_branch`  out  1  result is a branch condition; `res_data` bit 0 = taken.
- `res_illegal`  out  1  the instruction did not decode.
- `illegal_cnt`  out  CNT_W  count of illegal instructions retired; saturates at all-ones.

## Operation
Op codes driven on `alu_op`:
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
- 6 SLL, 7 SRL, 8 SRA.
- 9 SLT, 10 SLTU, 11 EQ, 12 NE, 13 SGE, 14 SGEU.
- 15 PASS `in2`; 0 = illegal (the ALU outputs 0).

Decode by opcode `instr[6:0]`:
- **OP (0110011).** `in1=rs1`, `in2=rs2`.
  - With funct7 `0000000`: funct3 000→ADD, 001→SLL, 010→SLT, 011→SLTU, 100→XOR, 101→SRL, 110→OR, 111→AND.
  - With funct7 `0100000`: funct3 000→SUB, 101→SRA.
  - Any other funct7 (including `0000001`, M-extension) is illegal.
- **OP-IMM (0010011).** `in1=rs1`, `in2=sign-extended instr[31:20]`. Same funct3 map as OP, with ADDI at 000.
  - 001 requires `instr[31:25]=0000000`.
  - 101 with `instr[31:25]=0000000`→SRL, `0100000`→SRA; any other value is illegal.
- **LUI (0110111).** `in1=0`, `in2={instr[31:12],12'b0}`, op 15.
- **BRANCH (1100011).** `in1=rs1`, `in2=rs2`.
  - funct3 000→EQ, 001→NE, 100→SLT, 101→SGE, 110→SLTU, 111→SGEU; 010 and 011 are illegal.
  - `res_branch=1`, `res_rd=0`.
- **Anything else** is illegal: op 0, `in1=in2=0`, `res_illegal=1`, `res_rd=0`.

Sideband flags (`res_rd`, `res_branch`, `res_illegal`) travel in stage A alongside the operands.

## Timing
- Stage A loads on `in_valid && in_ready`.
- Stage B loads `alu_out` and the sideband from stage A whenever stage A is valid and `b_adv = !res_valid || res_ready` holds.
- `in_ready = !a_valid || b_adv` (combinational; no bubble at full throughput).
- Latency: instruction accepted at edge N, ALU inputs valid after N, `res_valid` high after edge N+1. Sustains 1 instruction per cycle while `res_ready=1`.
- When stage A is not updated it holds its outputs; `alu_*` are stable while stalled. `res_*` are held while `res_valid && !res_ready`.
- `illegal_cnt` increments on the edge where an illegal result leaves stage B (`res_valid && res_ready && res_illegal`). It saturates and never wraps.
- Reset (async assert, mid-operation included):
  - `a_valid`, `res_valid` = 0.
  - `alu_in1`, `alu_in2`, `res_data` = 0.
  - `alu_op`, `res_rd`, `res_branch`, `res_illegal`, `illegal_cnt` = 0.
  - In-flight instructions are discarded. `in_ready` is 1 on the first cycle after release.
- Simultaneous accept, advance and retire in one cycle is legal and loses nothing.

## Configuration
- `ALU_DISPATCH_BRANCH_EN` defined: BRANCH decode as above.
- Not defined: opcode 1100011 decodes as illegal (op 0, `res_illegal=1`), `res_branch` is tied to 0, and no branch compare logic is built.

## Test plan
- **ADD.** ADD x3,x1,x2 with rs1=5, rs2=7, `res_ready=1`, accepted at edge N → `alu_op=1` after N; `res_valid`, `res_data=12`, `res_rd=3` after N+1.
- **SRAI.** SRAI x4,x1,4 with rs1=0x80000000 → `alu_op=8`, `alu_in2=4`, `res_data=0xF8000000`. SLLI with `instr[25]=1` → `res_illegal=1`, `res_data=0`.
- **BLT (macro defined).** rs1=0xFFFFFFFF, rs2=1 → `alu_op=9`, `res_branch=1`, `res_data=1`, `res_rd=0`. BLTU with the same operands → `res_data=0`. With the macro undefined → `res_illegal=1`.
- **Backpressure.** Issue 4 back-to-back ADDIs (imm 1..4 on rs1=0), hold `res_ready=0` for 3 cycles.
  - `in_ready` drops once both stages are full; held outputs are stable.
  - On release, results come out as 1, 2, 3, 4 in order with no loss or duplication.
- **Illegal counter.** Send MUL (funct7 `0000001`) three times → each result has `res_illegal=1` and `illegal_cnt=3` afterwards. With `CNT_W=2`, 5 illegal instructions → the counter stays at 3.
- **Reset mid-flight.** Assert `rst_n=0` asynchronously with both stages valid → all outputs drop to 0 immediately. After release, a fresh LUI x5,0x12345 gives `res_data=0x12345000`.
